// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and helpers for the scope acquisition front stage
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POSTTRIG,
        DONE
    } capture_state_t;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/scope_edge_detect.sv
// rtl/scope_edge_detect.sv - level-crossing detector over the stream of accepted samples
module scope_edge_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] level,
    input  logic              edge_sel,
    output logic              hit
);

    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              crossed;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (accept) begin
            prev       <= sample;
            prev_valid <= 1'b1;
        end
    end

    always_comb begin
        if (edge_sel == TRIG_RISING) begin
            crossed = (prev < level) && (sample >= level);
        end else begin
            crossed = (prev > level) && (sample <= level);
        end
        hit = accept && prev_valid && crossed;
    end

endmodule

// File: rtl/scope_trigger_capture.sv
// rtl/scope_trigger_capture.sv - decimating edge/auto-triggered frame capture into a circular buffer
module scope_trigger_capture
    import scope_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 7,
    parameter int AUTO_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] trig_level_i,
    input  logic              trig_edge_i,
    input  logic              trig_auto_i,
    input  logic [2:0]        decim_i,
    input  logic              arm_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] trig_pos_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DEPTH = depth(ADDR_W);
    localparam int HALF  = DEPTH / 2;

    capture_state_t    state, next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [6:0]        decim_cnt;
    logic [6:0]        decim_mask;
    logic [2:0]        decim_r;
    logic [15:0]       timeout_cnt;
    logic              capturing, arm_ok, accept, edge_hit, auto_hit, trigger;
    logic              pretrig_last, post_last, busy_d, done_d;

    scope_edge_detect #(.DATA_W(DATA_W)) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (arm_ok),
        .accept   (accept),
        .sample   (sample_i),
        .level    (trig_level_i),
        .edge_sel (trig_edge_i),
        .hit      (edge_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (arm_i)        next_state = PRETRIG;
            PRETRIG:    if (pretrig_last) next_state = ARMED;
            ARMED:      if (trigger)      next_state = POSTTRIG;
            POSTTRIG:   if (post_last)    next_state = DONE;
            default:                      next_state = IDLE;
        endcase
    end

    always_comb begin
        capturing    = (state == PRETRIG) || (state == ARMED) || (state == POSTTRIG);
        arm_ok       = arm_i && ((state == IDLE) || (state == DONE));
        decim_mask   = 7'((1 << decim_r) - 1);
        accept       = capturing && sample_valid_i && (decim_cnt == 7'd0);
        // The auto timeout fires on the accepted sample that completes the count.
        auto_hit     = (state == ARMED) && accept && trig_auto_i
                       && (timeout_cnt == 16'(AUTO_TIMEOUT - 1));
        trigger      = (state == ARMED) && (edge_hit || auto_hit);
        pretrig_last = (state == PRETRIG) && accept && (wr_ptr == ADDR_W'(HALF - 1));
        post_last    = (state == POSTTRIG) && accept
                       && (wr_ptr == trig_pos_o + ADDR_W'(HALF - 1));
        busy_d       = (next_state == PRETRIG) || (next_state == ARMED)
                       || (next_state == POSTTRIG);
        done_d       = (next_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            decim_cnt   <= '0;
            decim_r     <= '0;
            timeout_cnt <= '0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_we_o    <= 1'b0;
            trig_pos_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            mem_we_o <= accept;
            busy_o   <= busy_d;
            done_o   <= done_d;
            if (accept) begin
                mem_addr_o <= wr_ptr;
                mem_data_o <= sample_i;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (trigger) begin
                trig_pos_o <= wr_ptr;
            end
            if ((state == ARMED) && accept && trig_auto_i) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
            if (arm_ok) begin
                wr_ptr      <= '0;
                decim_cnt   <= '0;
                decim_r     <= decim_i;
                timeout_cnt <= '0;
            end else if (capturing && sample_valid_i) begin
                decim_cnt <= (decim_cnt == decim_mask) ? 7'd0 : decim_cnt + 7'd1;
            end
        end
    end

endmodule
